ram8: RTL and testbench
=======================

// Module: ram8
// PURPOSE
//   8-word x WIDTH-bit read/write memory. It is the first storage stage that
//   consumes the combinational gate library directly.
//   Write-enable is decoded by a DMux8Way-style one-hot stage. Read data is
//   selected by a Mux8Way16-style tree. Each word is a loadable register built
//   as DFF plus Mux feedback.
//   This block is the building unit for ram64 and larger RAMs, and for the
//   register file feeding the ALU.
// PARAMETERS
//   WIDTH   16   data word width in bits. Only 16 is supported by the Mux8Way16 read tree.
// PORTS
//   clk      input   1      single clock, rising-edge
//   rst      input   1      reset, asynchronous, active-high
//   in       input   WIDTH  write data
//   load     input   1      write enable for the addressed word
//   address  input   3      word select, 0..7, for both read and write
//   out      output  WIDTH  read data of the addressed word
// BEHAVIOUR
//   Clocking/reset:
//   - one clock (clk); reset (rst) is asynchronous and active-high
//   - rst=1 clears all 8 words to 0 immediately, with no clock edge needed
//   - out therefore reads 0 for any address while rst=1 and after release
//   - rst has priority over load; a write on the same edge as rst is discarded
//   - release of rst is sampled on clk; the first write is possible on the first
//     rising edge with rst=0
//   Write:
//   - on rising clk, if load=1: word[address] <= in
//   - the other 7 words hold
//   - load=0: all words hold
//   - no partial or byte writes
//   - load is decoded one-hot: exactly one word-enable is active when load=1,
//     and none when load=0
//   Read:
//   - combinational, zero latency: out = word[address]
//   - out follows address changes within the same cycle, with no registering
//   Read-during-write (same address, load=1):
//   - before the edge, out shows the OLD value
//   - after the edge, out shows in
//   - no write-through bypass
//   Back-to-back writes to the same address: the last edge wins.
//   Address range: all 3-bit values are valid. There is no out-of-range case
//   and no wrap logic.
//   State: 8 x WIDTH flops only. No FSM, no handshake; load is a single-cycle
//   qualifier.
//   X handling: an X on load or address must not corrupt unaddressed words when
//   load=0. Simulation only.
// TESTING
//   1. Reset: pulse rst=1 mid-cycle with no clk edge; sweep address 0..7
//      -> out=16'h0000 for every address.
//   2. Single write: address=3, in=16'h1234, load=1 for one edge, then load=0
//      -> out=16'h1234 at addr 3; addrs 0-2 and 4-7 read 16'h0000.
//   3. Read-during-write: addr 5 holds 16'hAAAA; apply in=16'h5555, load=1
//      -> out=16'hAAAA before the edge, 16'h5555 after it.
//   4. Aliasing: write word k = 16'h1111*(k+1) for k=0..7, then read all
//      -> each address returns its own value; no cross-writes.
//   5. Hold/priority: load=0 with in=16'hFFFF for 4 edges -> contents unchanged.
//      Then assert rst on the same edge as load=1, in=16'hBEEF, addr=2
//      -> all words 0.
//   6. Overwrite: two consecutive edges at addr 7 with 16'h0F0F then 16'hF0F0
//      -> out=16'hF0F0.

Source files
------------

// File: rtl/ram8.sv
// ram8: 8-word x WIDTH-bit memory with a one-hot write decode, per-word load
// registers (flop plus hold-mux feedback) and a three-level 8:1 read mux tree.
module ram8 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic [2:0]       address,
    output logic [WIDTH-1:0] out
);

    logic [7:0]       wen_s;
    logic [WIDTH-1:0] word_r      [8];
    logic [WIDTH-1:0] word_next_s [8];
    logic [WIDTH-1:0] lvl1_s      [4];
    logic [WIDTH-1:0] lvl2_s      [2];

    // One-hot write-enable decode; an unknown load or address yields no enable
    always_comb begin
        wen_s = 8'b0000_0000;
        if (load == 1'b1) begin
            case (address)
                3'd0:    wen_s = 8'b0000_0001;
                3'd1:    wen_s = 8'b0000_0010;
                3'd2:    wen_s = 8'b0000_0100;
                3'd3:    wen_s = 8'b0000_1000;
                3'd4:    wen_s = 8'b0001_0000;
                3'd5:    wen_s = 8'b0010_0000;
                3'd6:    wen_s = 8'b0100_0000;
                3'd7:    wen_s = 8'b1000_0000;
                default: wen_s = 8'b0000_0000;
            endcase
        end else begin
            wen_s = 8'b0000_0000;
        end
    end

    // Per-word hold mux: load new data only when this word is enabled
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            if (wen_s[i] == 1'b1) begin
                word_next_s[i] = in;
            end else begin
                word_next_s[i] = word_r[i];
            end
        end
    end

    // Word storage; reset clears every word immediately and beats a same-edge write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                word_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                word_r[i] <= word_next_s[i];
            end
        end
    end

    // Combinational read tree: address[0] picks pairs, [1] quads, [2] halves
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            if (address[0] == 1'b1) begin
                lvl1_s[i] = word_r[2*i+1];
            end else begin
                lvl1_s[i] = word_r[2*i];
            end
        end
        for (int j = 0; j < 2; j++) begin
            if (address[1] == 1'b1) begin
                lvl2_s[j] = lvl1_s[2*j+1];
            end else begin
                lvl2_s[j] = lvl1_s[2*j];
            end
        end
        if (address[2] == 1'b1) begin
            out = lvl2_s[1];
        end else begin
            out = lvl2_s[0];
        end
    end

endmodule

// File: tb/tb_ram8.sv
// tb_ram8: self-checking bench for ram8, comparing every read against an
// array model of the eight words updated from the write rules.
`timescale 1ns/100ps
module tb_ram8;

    logic        clk;
    logic        rst;
    logic [15:0] in;
    logic        load;
    logic [2:0]  address;
    logic [15:0] out;

    logic [15:0] mem_m [8];
    int          checks;
    int          errors;

    ram8 #(.WIDTH(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .in      (in),
        .load    (load),
        .address (address),
        .out     (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic write_word(input logic [2:0] a, input logic [15:0] d);
        address = a;
        in      = d;
        load    = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        mem_m[a] = d;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 8; k++) write_word(k[2:0], 16'($urandom_range(1, 16'hFFFF)));
        @(negedge clk);
        address = 3'd4;
        rst = 1'b1;
        #1;
        checks++;
        if (out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_async: out=%h expected=%h", out, 16'h0000);
        end
        for (int k = 0; k < 8; k++) begin
            address = k[2:0];
            #0.4;
            mem_m[k] = 16'h0000;
            checks++;
            if (out !== 16'h0000) begin
                errors++;
                $display("FAIL reset_sweep addr=%0d: out=%h expected=%h", k, out, 16'h0000);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++) begin
            address = k[2:0];
            #1;
            checks++;
            if (out !== 16'h0000) begin
                errors++;
                $display("FAIL reset_release addr=%0d: out=%h expected=%h", k, out, 16'h0000);
            end
        end
    endtask

    task automatic test_single_write();
        write_word(3'd3, 16'h1234);
        for (int k = 0; k < 8; k++) begin
            address = k[2:0];
            #1;
            checks++;
            if (out !== ((k == 3) ? 16'h1234 : 16'h0000)) begin
                errors++;
                $display("FAIL single_write addr=%0d: out=%h expected=%h", k, out,
                         (k == 3) ? 16'h1234 : 16'h0000);
            end
        end
    endtask

    task automatic test_read_during_write();
        write_word(3'd5, 16'hAAAA);
        address = 3'd5;
        in      = 16'h5555;
        load    = 1'b1;
        #1;
        checks++;
        if (out !== 16'hAAAA) begin
            errors++;
            $display("FAIL rdw_before: out=%h expected=%h", out, 16'hAAAA);
        end
        @(posedge clk);
        #1;
        load = 1'b0;
        mem_m[5] = 16'h5555;
        checks++;
        if (out !== 16'h5555) begin
            errors++;
            $display("FAIL rdw_after: out=%h expected=%h", out, 16'h5555);
        end
    endtask

    task automatic test_aliasing();
        for (int k = 0; k < 8; k++) write_word(k[2:0], 16'(16'h1111 * (k + 1)));
        for (int k = 7; k >= 0; k--) begin
            address = k[2:0];
            #1;
            checks++;
            if (out !== 16'(16'h1111 * (k + 1))) begin
                errors++;
                $display("FAIL aliasing addr=%0d: out=%h expected=%h", k, out, 16'(16'h1111 * (k + 1)));
            end
        end
    endtask

    task automatic test_hold_priority();
        load = 1'b0;
        in   = 16'hFFFF;
        for (int e = 0; e < 4; e++) begin
            address = e[2:0];
            @(posedge clk);
            #1;
        end
        // unknown address with load low must leave every word alone
        address = 3'bxxx;
        @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++) begin
            address = k[2:0];
            #1;
            checks++;
            if (out !== mem_m[k]) begin
                errors++;
                $display("FAIL hold addr=%0d: out=%h expected=%h", k, out, mem_m[k]);
            end
        end
        @(negedge clk);
        address = 3'd2;
        in      = 16'hBEEF;
        load    = 1'b1;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        rst  = 1'b0;
        for (int k = 0; k < 8; k++) mem_m[k] = 16'h0000;
        for (int k = 0; k < 8; k++) begin
            address = k[2:0];
            #1;
            checks++;
            if (out !== 16'h0000) begin
                errors++;
                $display("FAIL rst_priority addr=%0d: out=%h expected=%h", k, out, 16'h0000);
            end
        end
    endtask

    task automatic test_overwrite();
        address = 3'd7;
        in      = 16'h0F0F;
        load    = 1'b1;
        @(posedge clk);
        #1;
        in = 16'hF0F0;
        @(posedge clk);
        #1;
        load = 1'b0;
        mem_m[7] = 16'hF0F0;
        checks++;
        if (out !== 16'hF0F0) begin
            errors++;
            $display("FAIL overwrite: out=%h expected=%h", out, 16'hF0F0);
        end
    endtask

    task automatic test_random();
        logic [2:0] peek;
        for (int n = 0; n < 300; n++) begin
            address = 3'($urandom_range(0, 7));
            in      = 16'($urandom);
            load    = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (out !== mem_m[address]) begin
                errors++;
                $display("FAIL random_pre n=%0d addr=%0d: out=%h expected=%h", n, address, out, mem_m[address]);
            end
            @(posedge clk);
            #1;
            if (load) mem_m[address] = in;
            load = 1'b0;
            peek = 3'($urandom_range(0, 7));
            address = peek;
            #1;
            checks++;
            if (out !== mem_m[peek]) begin
                errors++;
                $display("FAIL random_post n=%0d addr=%0d: out=%h expected=%h", n, peek, out, mem_m[peek]);
            end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        load    = 1'b0;
        in      = 16'h0000;
        address = 3'd0;
        for (int k = 0; k < 8; k++) mem_m[k] = 16'h0000;
        #12;
        rst = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_write();
        test_read_during_write();
        test_aliasing();
        test_hold_priority();
        test_overwrite();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
